uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_loader_pkg.sv | 20 ++
 rtl/uart_rx_core.sv | 130 +++++++++++++
 rtl/uart_prog_loader.sv | 96 +++++++++
 tb/tb_uart_prog_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StRecover
  } rx_state_e;

  localparam logic [31:0] SENTINEL_DEFAULT = 32'h0000_0FFF;
  localparam logic [15:0] MIN_CPB          = 16'd4;

  // Bit periods shorter than MIN_CPB leave no room for a mid-bit sample.
  function automatic logic [15:0] clamp_cpb(input logic [15:0] cpb);
    return (cpb < MIN_CPB) ? MIN_CPB : cpb;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchronizer, bit-timing FSM, byte/frame-error pulses.
module uart_rx_core
  import uart_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  input  logic [15:0] i_cpb,
  input  logic        i_enable,
  output logic        o_start,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte,
  output logic        o_frame_err
);

  rx_state_e   r_state, w_state_d;
  logic        r_sync1, r_sync2, r_rx_prev;
  logic [15:0] r_cpb, w_cpb_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [2:0]  r_bit, w_bit_d;
  logic [7:0]  r_shift, w_shift_d;
  logic        r_valid, w_valid_d;
  logic        r_ferr, w_ferr_d;
  logic        r_start, w_start_d;
  logic        w_rx, w_fall;

  assign w_rx   = r_sync2;
  assign w_fall = r_rx_prev & ~r_sync2;

  // Synchronizer and edge-detect history; idle line level is 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cpb   <= 16'd0;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cpb   <= w_cpb_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_valid <= w_valid_d;
      r_ferr  <= w_ferr_d;
      r_start <= w_start_d;
    end
  end

  // Next-state logic: mid-bit sampling, CPB/2 into the start bit then every CPB.
  always_comb begin
    w_state_d = r_state;
    w_cpb_d   = r_cpb;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_valid_d = 1'b0;
    w_ferr_d  = 1'b0;
    w_start_d = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_enable && w_fall) begin
          w_state_d = StStart;
          w_cpb_d   = clamp_cpb(i_cpb);
          w_cnt_d   = 16'd0;
          w_start_d = 1'b1;
        end
      end
      StStart: begin
        if (r_cnt == (r_cpb >> 1) - 16'd1) begin
          w_cnt_d   = 16'd0;
          w_bit_d   = 3'd0;
          w_state_d = w_rx ? StIdle : StData;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StData: begin
        if (r_cnt == r_cpb - 16'd1) begin
          w_cnt_d   = 16'd0;
          w_shift_d = {w_rx, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_d = StStop;
          else               w_bit_d   = r_bit + 3'd1;
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StStop: begin
        if (r_cnt == r_cpb - 16'd1) begin
          w_cnt_d = 16'd0;
          if (w_rx) begin
            w_valid_d = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_ferr_d  = 1'b1;
            w_state_d = StRecover;
          end
        end else begin
          w_cnt_d = r_cnt + 16'd1;
        end
      end
      StRecover: begin
        if (w_rx) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_start      = r_start;
  assign o_byte_valid = r_valid;
  assign o_byte       = r_shift;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a program over UART: bytes -> little-endian words -> sequential memory writes.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned ADDR_W   = 13,
  parameter logic [31:0] SENTINEL = SENTINEL_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_rx_i,
  input  logic [15:0]       io_CLK_PER_BIT,
  output logic              io_mem_we_o,
  output logic [ADDR_W-1:0] io_mem_addr_o,
  output logic [31:0]       io_mem_wdata_o,
  output logic              io_busy_o,
  output logic              io_done_o,
  output logic              io_frame_err_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic              w_start, w_byte_valid, w_frame_err;
  logic [7:0]        w_byte;
  logic [31:0]       w_word;
  logic [31:0]       r_word;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W-1:0] r_addr, r_mem_addr;
  logic [31:0]       r_wdata;
  logic              r_we, r_busy, r_done, r_ferr;

  uart_rx_core u_rx_core (
    .i_clk        (clock),
    .i_rst_n      (reset_n),
    .i_rx         (io_rx_i),
    .i_cpb        (io_CLK_PER_BIT),
    .i_enable     (~r_done),
    .o_start      (w_start),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (w_frame_err)
  );

  // Merge the incoming byte into its little-endian lane.
  always_comb begin
    w_word = r_word;
    case (r_byte_cnt)
      2'd0: w_word[7:0]   = w_byte;
      2'd1: w_word[15:8]  = w_byte;
      2'd2: w_word[23:16] = w_byte;
      2'd3: w_word[31:24] = w_byte;
      default: w_word = r_word;
    endcase
  end

  // Word assembly, write strobe, addressing and sticky status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_word     <= 32'd0;
      r_byte_cnt <= 2'd0;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_wdata    <= 32'd0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_frame_err) r_ferr <= 1'b1;
      if (w_start)     r_busy <= 1'b1;
      if (w_byte_valid && !r_done) begin
        r_word     <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          if (w_word == SENTINEL) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_we       <= 1'b1;
            r_wdata    <= w_word;
            r_mem_addr <= r_addr;
            r_addr     <= r_addr + ADDR_ONE;
          end
        end
      end
    end
  end

  assign io_mem_we_o    = r_we;
  assign io_mem_addr_o  = r_mem_addr;
  assign io_mem_wdata_o = r_wdata;
  assign io_busy_o      = r_busy;
  assign io_done_o      = r_done;
  assign io_frame_err_o = r_ferr;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: default instance plus a 2-bit-address instance.
module tb_uart_prog_loader;
  import uart_loader_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        rx_a, rx_b;
  logic [15:0] cpb_a, cpb_b;

  logic        a_we, a_busy, a_done, a_ferr;
  logic [12:0] a_addr;
  logic [31:0] a_wdata;
  logic        b_we, b_busy, b_done, b_ferr;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;

  uart_prog_loader dut_a (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_rx_i        (rx_a),
    .io_CLK_PER_BIT (cpb_a),
    .io_mem_we_o    (a_we),
    .io_mem_addr_o  (a_addr),
    .io_mem_wdata_o (a_wdata),
    .io_busy_o      (a_busy),
    .io_done_o      (a_done),
    .io_frame_err_o (a_ferr)
  );

  uart_prog_loader #(.ADDR_W(2)) dut_b (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_rx_i        (rx_b),
    .io_CLK_PER_BIT (cpb_b),
    .io_mem_we_o    (b_we),
    .io_mem_addr_o  (b_addr),
    .io_mem_wdata_o (b_wdata),
    .io_busy_o      (b_busy),
    .io_done_o      (b_done),
    .io_frame_err_o (b_ferr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitors: log every strobe cycle and the longest strobe run.
  logic [31:0] a_addr_q[$], a_data_q[$], b_addr_q[$], b_data_q[$];
  int a_run = 0, a_maxrun = 0, b_run = 0, b_maxrun = 0;

  always @(negedge clock) begin
    if (a_we) begin
      a_addr_q.push_back(32'(a_addr));
      a_data_q.push_back(a_wdata);
      a_run++;
      if (a_run > a_maxrun) a_maxrun = a_run;
    end else a_run = 0;
    if (b_we) begin
      b_addr_q.push_back(32'(b_addr));
      b_data_q.push_back(b_wdata);
      b_run++;
      if (b_run > b_maxrun) b_maxrun = b_run;
    end else b_run = 0;
  end

  // All stimulus tasks start and end #1 after a rising edge.
  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input bit sel, input int cpb, input logic [7:0] d, input logic stop);
    drive(sel, 1'b0);
    hold(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      hold(cpb);
    end
    drive(sel, stop);
    hold(cpb);
    drive(sel, 1'b1);
    hold(4);
  endtask

  task automatic send_word(input bit sel, input int cpb, input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(sel, cpb, w[8*k +: 8], 1'b1);
    hold(8);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    hold(3);
    reset_n = 1'b1;
    hold(3);
    a_addr_q.delete(); a_data_q.delete(); a_maxrun = 0;
    b_addr_q.delete(); b_data_q.delete(); b_maxrun = 0;
  endtask

  logic [31:0] words_b[5];

  initial begin
    reset_n = 1'b0;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    cpb_a   = 16'd16;
    cpb_b   = 16'd2;
    @(posedge clock);
    #1;

    // Reset state
    do_reset();
    check("rst_we",    32'(a_we),    32'd0);
    check("rst_addr",  32'(a_addr),  32'd0);
    check("rst_wdata", a_wdata,      32'd0);
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_done",  32'(a_done),  32'd0);
    check("rst_ferr",  32'(a_ferr),  32'd0);

    // Single word 0x00000513
    send_word(1'b0, 16, 32'h0000_0513);
    check("w1_count", a_addr_q.size(), 32'd1);
    if (a_addr_q.size() >= 1) begin
      check("w1_addr", a_addr_q[0], 32'd0);
      check("w1_data", a_data_q[0], 32'h0000_0513);
    end
    check("w1_pulse", a_maxrun, 32'd1);
    check("w1_busy",  32'(a_busy), 32'd1);
    check("w1_done",  32'(a_done), 32'd0);

    // Two words then sentinel; later traffic ignored
    do_reset();
    send_word(1'b0, 16, 32'h0000_0513);
    send_word(1'b0, 16, 32'h00A0_0093);
    send_word(1'b0, 16, 32'h0000_0FFF);
    check("sn_count", a_addr_q.size(), 32'd2);
    if (a_addr_q.size() >= 2) begin
      check("sn_addr0", a_addr_q[0], 32'd0);
      check("sn_addr1", a_addr_q[1], 32'd1);
      check("sn_data1", a_data_q[1], 32'h00A0_0093);
    end
    check("sn_done", 32'(a_done), 32'd1);
    check("sn_busy", 32'(a_busy), 32'd0);
    send_word(1'b0, 16, 32'h1122_3344);
    check("sn_after_count", a_addr_q.size(), 32'd2);
    check("sn_after_done",  32'(a_done), 32'd1);

    // Frame error on 3rd byte; partial word continues with next good bytes
    do_reset();
    send_byte(1'b0, 16, 8'h11, 1'b1);
    send_byte(1'b0, 16, 8'h22, 1'b1);
    send_byte(1'b0, 16, 8'h33, 1'b0);
    send_byte(1'b0, 16, 8'h44, 1'b1);
    send_byte(1'b0, 16, 8'h55, 1'b1);
    hold(8);
    check("fe_ferr",  32'(a_ferr), 32'd1);
    check("fe_count", a_addr_q.size(), 32'd1);
    if (a_addr_q.size() >= 1) begin
      check("fe_addr", a_addr_q[0], 32'd0);
      check("fe_data", a_data_q[0], 32'h5544_2211);
    end

    // Short low glitch on rx
    do_reset();
    rx_a = 1'b0;
    hold(3);
    rx_a = 1'b1;
    hold(60);
    check("gl_count", a_addr_q.size(), 32'd0);
    check("gl_ferr",  32'(a_ferr), 32'd0);
    check("gl_state", 32'(dut_a.u_rx_core.r_state), 32'(StIdle));
    send_word(1'b0, 16, 32'hCAFE_0001);
    check("gl_word_count", a_addr_q.size(), 32'd1);
    if (a_data_q.size() >= 1) check("gl_word_data", a_data_q[0], 32'hCAFE_0001);

    // Reset during DATA of the 2nd byte
    do_reset();
    send_byte(1'b0, 16, 8'hAA, 1'b1);
    rx_a = 1'b0;
    hold(16);
    rx_a = 1'b1;
    hold(16);
    rx_a = 1'b0;
    hold(32);
    reset_n = 1'b0;
    rx_a    = 1'b1;
    hold(3);
    reset_n = 1'b1;
    hold(200);
    check("mr_count", a_addr_q.size(), 32'd0);
    send_word(1'b0, 16, 32'h1234_5678);
    check("mr_word_count", a_addr_q.size(), 32'd1);
    if (a_addr_q.size() >= 1) begin
      check("mr_addr", a_addr_q[0], 32'd0);
      check("mr_data", a_data_q[0], 32'h1234_5678);
    end

    // ADDR_W=2 wrap with CPB driven as 2 (clamped to 4)
    do_reset();
    words_b[0] = 32'h0000_0001;
    words_b[1] = 32'h0000_0102;
    words_b[2] = 32'h0001_0203;
    words_b[3] = 32'hA5A5_5A5A;
    words_b[4] = 32'h8000_0000;
    for (int i = 0; i < 5; i++) send_word(1'b1, 4, words_b[i]);
    check("aw_count", b_addr_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (b_addr_q.size() > i) begin
        check($sformatf("aw_addr%0d", i), b_addr_q[i], 32'(i % 4));
        check($sformatf("aw_data%0d", i), b_data_q[i], words_b[i]);
      end
    end
    check("aw_pulse", b_maxrun, 32'd1);
    check("aw_ferr",  32'(b_ferr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
